trail_renderer: RTL



---
 rtl/trail_renderer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/trail_renderer.sv
// Motion-trail overlay: keeps a DEPTH-deep history of tracked tip positions and
// draws it per pixel as shrinking, fading square blocks, newest entry on top.
module trail_renderer #(
    parameter int          DEPTH      = 6,
    parameter int          BASE_SIZE  = 16,
    parameter int          SIZE_STEP  = 3,
    parameter int          MIN_SIZE   = 2,
    parameter logic [23:0] BASE_COLOR = 24'hFF_FF_FF,
    parameter int          DECIM      = 1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        nf_in,
    input  logic        clear_in,
    input  logic        valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    output logic [23:0] color_out,
    output logic        hit_out,
    output logic [3:0]  age_out
);

    localparam int                CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    function automatic logic [11:0] size_of(input int age);
        int raw;
        raw = BASE_SIZE - age * SIZE_STEP;
        return 12'((raw < MIN_SIZE) ? MIN_SIZE : raw);
    endfunction

    function automatic logic [23:0] color_of(input int age);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = BASE_COLOR[23:16] >> age;
        g = BASE_COLOR[15:8] >> age;
        b = BASE_COLOR[7:0] >> age;
        return {r, g, b};
    endfunction

    logic [10:0]      x_r [DEPTH];
    logic [9:0]       y_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [CNT_W-1:0] decim_cnt_r;
    logic             capture_s;
    logic [DEPTH-1:0] entry_hit_s;
    logic             hit_s;
    logic [3:0]       age_s;
    logic [23:0]      color_s;

    // Capture decision: clear always wins over a simultaneous new-frame pulse.
    always_comb begin
        capture_s = 1'b0;
        if (nf_in && !clear_in && (decim_cnt_r == '0)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // History shift register and decimation counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                x_r[i] <= 11'd0;
                y_r[i] <= 10'd0;
            end
            valid_r     <= '0;
            decim_cnt_r <= '0;
        end else if (clear_in) begin
            valid_r     <= '0;
            decim_cnt_r <= '0;
        end else if (nf_in) begin
            if (decim_cnt_r == CNT_LAST) begin
                decim_cnt_r <= '0;
            end else begin
                decim_cnt_r <= decim_cnt_r + CNT_W'(1);
            end
            if (capture_s) begin
                x_r[0]  <= x_in;
                y_r[0]  <= y_in;
                valid_r <= {valid_r[DEPTH-2:0], valid_in};
                for (int i = 1; i < DEPTH; i++) begin
                    x_r[i] <= x_r[i-1];
                    y_r[i] <= y_r[i-1];
                end
            end
        end
    end

    // Bounds are widened to 12 bits so blocks near the right/bottom edge never wrap.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        localparam logic [11:0] SZ = size_of(g);
        logic [11:0] hx_s;
        logic [11:0] vy_s;
        logic [11:0] x0_s;
        logic [11:0] y0_s;
        assign hx_s = {1'b0, hcount_in};
        assign vy_s = {2'b00, vcount_in};
        assign x0_s = {1'b0, x_r[g]};
        assign y0_s = {2'b00, y_r[g]};
        assign entry_hit_s[g] = valid_r[g]
                              && (hx_s >= x0_s) && (hx_s < x0_s + SZ)
                              && (vy_s >= y0_s) && (vy_s < y0_s + SZ);
    end

    // Priority pick: walking from oldest to newest lets the lowest hitting age win.
    always_comb begin
        hit_s   = 1'b0;
        age_s   = 4'd0;
        color_s = 24'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit_s   = entry_hit_s[i] ? 1'b1        : hit_s;
            age_s   = entry_hit_s[i] ? 4'(i)       : age_s;
            color_s = entry_hit_s[i] ? color_of(i) : color_s;
        end
    end

    // Registered pixel outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            color_out <= 24'd0;
            hit_out   <= 1'b0;
            age_out   <= 4'd0;
        end else begin
            color_out <= color_s;
            hit_out   <= hit_s;
            age_out   <= age_s;
        end
    end

endmodule
